// File: rtl/instr_pkg.sv
// Shared MIPS-31 instruction constants: one-hot select indices, opcodes, funct codes
// and field positions. The one-hot decoder uses the same bit order.
package instr_pkg;

  localparam int IDX_ADD   = 0;
  localparam int IDX_ADDU  = 1;
  localparam int IDX_SUB   = 2;
  localparam int IDX_SUBU  = 3;
  localparam int IDX_AND   = 4;
  localparam int IDX_OR    = 5;
  localparam int IDX_XOR   = 6;
  localparam int IDX_NOR   = 7;
  localparam int IDX_SLT   = 8;
  localparam int IDX_SLTU  = 9;
  localparam int IDX_SLL   = 10;
  localparam int IDX_SRL   = 11;
  localparam int IDX_SRA   = 12;
  localparam int IDX_SLLV  = 13;
  localparam int IDX_SRLV  = 14;
  localparam int IDX_SRAV  = 15;
  localparam int IDX_JR    = 16;
  localparam int IDX_ADDI  = 17;
  localparam int IDX_ADDIU = 18;
  localparam int IDX_ANDI  = 19;
  localparam int IDX_ORI   = 20;
  localparam int IDX_XORI  = 21;
  localparam int IDX_LW    = 22;
  localparam int IDX_SW    = 23;
  localparam int IDX_BEQ   = 24;
  localparam int IDX_BNE   = 25;
  localparam int IDX_SLTI  = 26;
  localparam int IDX_SLTIU = 27;
  localparam int IDX_LUI   = 28;
  localparam int IDX_J     = 29;
  localparam int IDX_JAL   = 30;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  function automatic logic [5:0] r_funct(input int idx);
    case (idx)
      IDX_ADD:  r_funct = FN_ADD;
      IDX_ADDU: r_funct = FN_ADDU;
      IDX_SUB:  r_funct = FN_SUB;
      IDX_SUBU: r_funct = FN_SUBU;
      IDX_AND:  r_funct = FN_AND;
      IDX_OR:   r_funct = FN_OR;
      IDX_XOR:  r_funct = FN_XOR;
      IDX_NOR:  r_funct = FN_NOR;
      IDX_SLT:  r_funct = FN_SLT;
      IDX_SLTU: r_funct = FN_SLTU;
      IDX_SLL:  r_funct = FN_SLL;
      IDX_SRL:  r_funct = FN_SRL;
      IDX_SRA:  r_funct = FN_SRA;
      IDX_SLLV: r_funct = FN_SLLV;
      IDX_SRLV: r_funct = FN_SRLV;
      IDX_SRAV: r_funct = FN_SRAV;
      IDX_JR:   r_funct = FN_JR;
      default:  r_funct = '0;
    endcase
  endfunction

  function automatic logic [5:0] i_op(input int idx);
    case (idx)
      IDX_ADDI:  i_op = OP_ADDI;
      IDX_ADDIU: i_op = OP_ADDIU;
      IDX_ANDI:  i_op = OP_ANDI;
      IDX_ORI:   i_op = OP_ORI;
      IDX_XORI:  i_op = OP_XORI;
      IDX_LW:    i_op = OP_LW;
      IDX_SW:    i_op = OP_SW;
      IDX_BEQ:   i_op = OP_BEQ;
      IDX_BNE:   i_op = OP_BNE;
      IDX_SLTI:  i_op = OP_SLTI;
      IDX_SLTIU: i_op = OP_SLTIU;
      IDX_LUI:   i_op = OP_LUI;
      default:   i_op = '0;
    endcase
  endfunction

  // Constant-shift instructions are the only R-types that carry a shamt.
  function automatic logic is_shift_imm(input int idx);
    is_shift_imm = (idx == IDX_SLL) || (idx == IDX_SRL) || (idx == IDX_SRA);
  endfunction

endpackage

// File: rtl/instr_enc_if.sv
// Request and result handshakes of the instruction encoder.
interface instr_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sel;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a full FIFO refuses pushes even when
// a pop happens in the same cycle. The head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers mask whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_enc.sv
// Streaming MIPS-31 encoder: one-hot select plus operands in, 32-bit instruction
// words out through a small FIFO, with pop and illegal-request counters.
module instr_enc
  import instr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  instr_enc_if.slave       bus,
  output logic             err,
  output logic [CNT_W-1:0] out_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic logic [31:0] encode(
    input logic [31:0] sel,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    int          idx;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  sh_f;
    logic [31:0] w;
    idx  = 0;
    rs_f = rs;
    rt_f = rt;
    rd_f = rd;
    sh_f = '0;
    for (int i = 0; i < 31; i++) begin
      if (sel[i]) idx = i;
    end
    if (idx <= IDX_JR) begin
      if (is_shift_imm(idx)) begin
        rs_f = '0;
        sh_f = shamt;
      end
      if (idx == IDX_JR) begin
        rt_f = '0;
        rd_f = '0;
      end
      w = (32'(OP_RTYPE) << OP_LSB) | (32'(rs_f) << RS_LSB) | (32'(rt_f) << RT_LSB) |
          (32'(rd_f) << RD_LSB) | (32'(sh_f) << SHAMT_LSB) | 32'(r_funct(idx));
    end else if (idx <= IDX_LUI) begin
      if (idx == IDX_LUI) rs_f = '0;
      w = (32'(i_op(idx)) << OP_LSB) | (32'(rs_f) << RS_LSB) | (32'(rt_f) << RT_LSB) |
          32'(imm);
    end else begin
      w = (32'((idx == IDX_J) ? OP_J : OP_JAL) << OP_LSB) | 32'(target);
    end
    return w;
  endfunction

  logic        full;
  logic        empty;
  logic        legal;
  logic        accept;
  logic        pop;
  logic [31:0] enc_word;

  assign legal    = $onehot(bus.in_sel[30:0]) && !bus.in_sel[31];
  assign accept   = bus.in_valid && bus.in_ready;
  assign pop      = bus.out_valid && bus.out_ready;
  assign enc_word = encode(bus.in_sel, bus.in_rs, bus.in_rt, bus.in_rd,
                           bus.in_shamt, bus.in_imm, bus.in_target);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && legal),
    .push_data (enc_word),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (bus.out_data)
  );

  // Illegal requests are still consumed; they only raise the error pulse and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      out_cnt <= '0;
      err_cnt <= '0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal) err_cnt <= err_cnt + 1'b1;
      if (pop)              out_cnt <= out_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: a queue-based reference model compared every
// cycle, plus directed vectors with hand-computed words.
module tb_instr_enc;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             err;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] err_cnt;

  instr_enc_if bus();

  instr_enc #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err     (err),
    .out_cnt (out_cnt),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference tables written straight from the instruction set listing.
  logic [5:0] r_funct_tbl [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                   6'h08};
  logic [5:0] i_op_tbl [12] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04,
                                6'h05, 6'h0A, 6'h0B, 6'h0F};

  logic [31:0] m_q [$];
  logic        m_err     = 1'b0;
  int          m_out_cnt = 0;
  int          m_err_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int b, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [4:0] sh, input logic [15:0] imm,
                                             input logic [25:0] tgt);
    logic shift_k;
    if (b < 17) begin
      shift_k = (b == 10) || (b == 11) || (b == 12);
      if (b == 16) return {6'b0, rs, 5'd0, 5'd0, 5'd0, r_funct_tbl[b]};
      return {6'b0, shift_k ? 5'd0 : rs, rt, rd, shift_k ? sh : 5'd0, r_funct_tbl[b]};
    end
    if (b < 29) return {i_op_tbl[b-17], (b == 28) ? 5'd0 : rs, rt, imm};
    return {(b == 29) ? 6'h02 : 6'h03, tgt};
  endfunction

  // Reference model: advances on each rising clock edge, cleared by reset at once.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_err     = 1'b0;
        m_out_cnt = 0;
        m_err_cnt = 0;
      end else begin
        automatic bit do_pop = (m_q.size() > 0) && bus.out_ready;
        automatic bit do_acc = bus.in_valid && (m_q.size() < DEPTH);
        automatic bit ok     = ($countones(bus.in_sel) == 1) && !bus.in_sel[31];
        automatic int b      = 0;
        for (int i = 0; i < 31; i++) if (bus.in_sel[i]) b = i;
        m_err = do_acc && !ok;
        if (m_err) m_err_cnt = (m_err_cnt + 1) % (1 << CNT_W);
        if (do_pop) begin
          void'(m_q.pop_front());
          m_out_cnt = (m_out_cnt + 1) % (1 << CNT_W);
        end
        if (do_acc && ok)
          m_q.push_back(model_word(b, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt,
                                   bus.in_imm, bus.in_target));
      end
    end
  end

  // Every falling edge the DUT must agree with the model on all outputs.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
      checkOutput("cmp_out_data", bus.out_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
      checkOutput("cmp_in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
      checkOutput("cmp_err", 32'(err), 32'(m_err));
      checkOutput("cmp_out_cnt", 32'(out_cnt), 32'(m_out_cnt));
      checkOutput("cmp_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    end
  end

  task automatic applyStimulus(input logic valid, input logic [31:0] sel,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh,
                               input logic [15:0] imm, input logic [25:0] tgt);
    bus.in_valid  = valid;
    bus.in_sel    = sel;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_shamt  = sh;
    bus.in_imm    = imm;
    bus.in_target = tgt;
  endtask

  // Push one legal word with out_ready high; it must show on the next cycle.
  task automatic encodeOne(input string name, input logic [31:0] sel, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] expected);
    applyStimulus(1'b1, sel, rs, rt, rd, sh, imm, tgt);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput(name, bus.out_data, expected);
    checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic illegalOne(input string name, input logic [31:0] sel,
                            input int exp_err_cnt);
    applyStimulus(1'b1, sel, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput({name, "_err"}, 32'(err), 32'd1);
    checkOutput({name, "_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
    checkOutput({name, "_nowrite"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, "_pulse"}, 32'(err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'h0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_out_cnt", 32'(out_cnt), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] legal words");
    bus.out_ready = 1'b1;
    encodeOne("add", 32'h1 << 0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 32'h00221820);
    @(negedge clk);
    checkOutput("add_out_cnt", 32'(out_cnt), 32'd1);
    @(posedge clk); #1;
    encodeOne("sll", 32'h1 << 10, 5'd9, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 32'h000220C0);
    encodeOne("lw", 32'h1 << 22, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0, 32'h8FA8FFFC);
    encodeOne("jal", 32'h1 << 30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h0C100000);
    encodeOne("jr", 32'h1 << 16, 5'd31, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h03E00008);

    $display("[TB] illegal selects");
    illegalOne("ill_two", 32'h00000003, 1);
    illegalOne("ill_b31", 32'h80000000, 2);
    illegalOne("ill_zero", 32'h00000000, 3);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h1 << 28, 5'd7, 5'd1, 5'd0, 5'd0, 16'(k), 26'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("bp_full_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_stall0", bus.out_data, 32'h3C010000);
    @(negedge clk);
    checkOutput("bp_stall1", bus.out_data, 32'h3C010000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_pop_blocks_push", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_word1", bus.out_data, 32'h3C010001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_word2", bus.out_data, 32'h3C010002);
    @(negedge clk);
    checkOutput("bp_word3", bus.out_data, 32'h3C010003);
    @(negedge clk);
    checkOutput("bp_word4", bus.out_data, 32'h3C010004);
    @(negedge clk);
    checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    $display("[TB] reset mid-stream");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h1, 5'd1, 5'd2, 5'(k), 5'd0, 16'h0, 26'h0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_data", bus.out_data, 32'h0);
    checkOutput("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
    checkOutput("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    encodeOne("post_rst_add", 32'h1, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 32'h00221820);

    $display("[TB] streaming and counter wrap");
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0)
        applyStimulus(1'b1, 32'h1 << ((i * 7) % 31), 5'(i), 5'(i + 3), 5'(i + 5), 5'(i + 1),
                      16'(i * 1111), 26'(i * 77777));
      else
        applyStimulus(1'b1, (i % 4 == 1) ? 32'h0 : (32'h80000000 | (32'h1 << (i % 31))),
                      5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("wrap_out_cnt", 32'(out_cnt), 32'd5);
    checkOutput("wrap_err_cnt", 32'(err_cnt), 32'd4);
    checkOutput("wrap_empty", 32'(bus.out_valid), 32'd0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
